// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the prio_enc_arb priority encoder/arbiter.
package prio_enc_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam int MAX_N     = 64;
  localparam int MAX_IDX_W = 6;

  function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_IDX_W-1:0] idx);
    return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/prio_enc_arb_if.sv
// Request/result bus between request sources, the encoder and its single consumer.
interface prio_enc_arb_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] grant;
  logic         busy;

  modport master (output req, ready, input  valid, idx, grant, busy);
  modport slave  (input  req, ready, output valid, idx, grant, busy);
endinterface

// File: rtl/prio_enc_core.sv
// Combinational search: found flag and index of the highest set request bit.
module prio_enc_core #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  // ascending scan, so the highest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/prio_enc_arb.sv
// Priority encoder with registered winner held under valid/ready.
// Define PRIO_ENC_RR_EN for round-robin search; otherwise fixed MSB-first priority.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  prio_enc_arb_if.slave  bus
);
  state_t       state, nxt;
  logic         found, accept, load;
  logic [W-1:0] core_idx, win, idx_q;
  logic [N-1:0] core_req, grant_q;

  assign accept = (state == HOLD) && bus.ready;
  assign load   = found && ((state == IDLE) || bus.ready);

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] rr_ptr, ptr;
  logic [W:0]   sum;

  // on an accepting edge the just-accepted index is already the new pointer
  assign ptr      = accept ? idx_q : rr_ptr;
  assign core_req = N'({bus.req, bus.req} >> ptr);
  assign sum      = {1'b0, core_idx} + {1'b0, ptr};
  assign win      = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= '0;
    else if (accept) rr_ptr <= idx_q;
  end
`else
  assign core_req = bus.req;
  assign win      = core_idx;
`endif

  prio_enc_core #(.N(N)) u_core (
    .req   (core_req),
    .found (found),
    .idx   (core_idx)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found) nxt = HOLD;
      HOLD:    if (bus.ready) nxt = found ? HOLD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        idx_q   <= win;
        grant_q <= N'(onehot_of(MAX_IDX_W'(win)));
      end else if (accept) begin
        idx_q   <= '0;
        grant_q <= '0;
      end
    end
  end

  assign bus.valid = (state == HOLD);
  assign bus.busy  = (state == HOLD);
  assign bus.idx   = idx_q;
  assign bus.grant = grant_q;
endmodule
